// File: rtl/seg7_pkg.sv
// Shared character codes for the seven-segment display path.
// Mode blocks and the scan driver agree on these 5-bit codes.
package seg7_pkg;

    localparam int CODE_W     = 5;
    localparam int SEG_W      = 7;
    localparam int NUM_DIGITS = 4;
    localparam int WORD_W     = CODE_W * NUM_DIGITS;

    typedef logic [CODE_W-1:0] code_t;

    localparam code_t C_0     = 5'd0;
    localparam code_t C_1     = 5'd1;
    localparam code_t C_2     = 5'd2;
    localparam code_t C_3     = 5'd3;
    localparam code_t C_4     = 5'd4;
    localparam code_t C_5     = 5'd5;
    localparam code_t C_S     = 5'd5;
    localparam code_t C_6     = 5'd6;
    localparam code_t C_7     = 5'd7;
    localparam code_t C_8     = 5'd8;
    localparam code_t C_9     = 5'd9;
    localparam code_t C_A     = 5'd10;
    localparam code_t C_C     = 5'd11;
    localparam code_t C_E     = 5'd12;
    localparam code_t C_F     = 5'd13;
    localparam code_t C_h     = 5'd14;
    localparam code_t C_L     = 5'd15;
    localparam code_t C_n     = 5'd16;
    localparam code_t C_o     = 5'd17;
    localparam code_t C_b     = 5'd18;
    localparam code_t C_d     = 5'd19;
    localparam code_t C_P     = 5'd20;
    localparam code_t C_J     = 5'd21;
    localparam code_t C_y     = 5'd22;
    localparam code_t C_U     = 5'd23;
    localparam code_t C_r     = 5'd24;
    localparam code_t C_t     = 5'd25;
    localparam code_t C_DASH  = 5'd26;
    localparam code_t C_UNDER = 5'd27;
    localparam code_t C_BLANK = 5'd31;

    localparam logic [SEG_W-1:0]      SEG_DARK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_DARK  = 4'hF;

    // Pick digit idx out of the packed word; digit 3 sits in the top bits.
    function automatic code_t code_at(input logic [WORD_W-1:0] word,
                                      input logic [1:0]        idx);
        code_t code;
        case (idx)
            2'd3:    code = word[19:15];
            2'd2:    code = word[14:10];
            2'd1:    code = word[9:5];
            default: code = word[4:0];
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational character-code to segment-pattern decoder.
// Output is active-high {g,f,e,d,c,b,a}; unused codes decode to blank.
module seg7_char_decode
    import seg7_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    output logic [SEG_W-1:0]  pattern
);

    always_comb begin
        pattern = 7'h00;
        case (code)
            C_0:     pattern = 7'h3F;
            C_1:     pattern = 7'h06;
            C_2:     pattern = 7'h5B;
            C_3:     pattern = 7'h4F;
            C_4:     pattern = 7'h66;
            C_5:     pattern = 7'h6D;
            C_6:     pattern = 7'h7D;
            C_7:     pattern = 7'h07;
            C_8:     pattern = 7'h7F;
            C_9:     pattern = 7'h6F;
            C_A:     pattern = 7'h77;
            C_C:     pattern = 7'h39;
            C_E:     pattern = 7'h79;
            C_F:     pattern = 7'h71;
            C_h:     pattern = 7'h74;
            C_L:     pattern = 7'h38;
            C_n:     pattern = 7'h54;
            C_o:     pattern = 7'h5C;
            C_b:     pattern = 7'h7C;
            C_d:     pattern = 7'h5E;
            C_P:     pattern = 7'h73;
            C_J:     pattern = 7'h1E;
            C_y:     pattern = 7'h6E;
            C_U:     pattern = 7'h3E;
            C_r:     pattern = 7'h50;
            C_t:     pattern = 7'h78;
            C_DASH:  pattern = 7'h40;
            C_UNDER: pattern = 7'h08;
            default: pattern = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode driver with per-slot blanking.
// The character word is captured once per frame so updates never tear mid-scan.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int BLANK_CYCLES = 1_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [WORD_W-1:0]     seg_data,
    input  logic [NUM_DIGITS-1:0] dp_data,
    output logic [NUM_DIGITS-1:0] an,
    output logic [SEG_W-1:0]      seg,
    output logic                  dp
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [1:0]       IDX_FIRST = 2'd3;

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            idx_q, idx_d;
    logic [WORD_W-1:0]     snap_seg_q, snap_seg_d;
    logic [NUM_DIGITS-1:0] snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;

    logic                  frame_start;
    logic                  slot_end;
    logic                  in_blank;
    code_t                 active_code;
    logic [SEG_W-1:0]      active_pattern;

    assign frame_start = (cnt_q == '0) && (idx_q == IDX_FIRST);
    assign slot_end    = (cnt_q == CNT_LAST);
    assign in_blank    = (cnt_q < CNT_BLANK);
    assign active_code = code_at(snap_seg_q, idx_q);

    seg7_char_decode u_decode (
        .code    (active_code),
        .pattern (active_pattern)
    );

    // Slot counter, digit index and the once-per-frame snapshot.
    always_comb begin
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        snap_seg_d = snap_seg_q;
        snap_dp_d  = snap_dp_q;
        if (!enable) begin
            cnt_d = '0;
            idx_d = IDX_FIRST;
        end else begin
            if (frame_start) begin
                snap_seg_d = seg_data;
                snap_dp_d  = dp_data;
            end
            if (slot_end) begin
                cnt_d = '0;
                idx_d = idx_q - 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output stage is driven from the current state, so pins lag cnt by one cycle.
    always_comb begin
        an_d  = AN_DARK;
        seg_d = SEG_DARK;
        dp_d  = 1'b1;
        if (enable && !in_blank) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = ~active_pattern;
            dp_d  = ~snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= IDX_FIRST;
            snap_seg_q <= {NUM_DIGITS{C_BLANK}};
            snap_dp_q  <= '0;
            an_q       <= AN_DARK;
            seg_q      <= SEG_DARK;
            dp_q       <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_seg_q <= snap_seg_d;
            snap_dp_q  <= snap_dp_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=8, BLANK_CYCLES=2.
// Frame table covers three frames; hand sequences cover enable-low and mid-slot reset.
module tb_seg7_scan_driver;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [19:0] seg_data;
    logic [3:0]  dp_data;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int n_vec;
    int n_fail;

    localparam logic [19:0] W_A = {5'd1, 5'd21, 5'd22, 5'd21};
    localparam logic [19:0] W_B = {5'd2, 5'd14, 5'd22, 5'd5};
    localparam logic [19:0] W_C = {5'd28, 5'd29, 5'd30, 5'd31};
    localparam logic [19:0] W_D = {5'd9, 5'd8, 5'd7, 5'd6};

    typedef struct {
        logic        rst;
        logic        en;
        logic [19:0] sd;
        logic [3:0]  dd;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t tbl[$];

    seg7_scan_driver #(
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .seg_data (seg_data),
        .dp_data  (dp_data),
        .an       (an),
        .seg      (seg),
        .dp       (dp)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // At most one anode may ever be active.
    always @(negedge clk) begin
        if (!$isunknown(an) && $countones(~an) > 1) begin
            n_fail++;
            $display("FAIL onehot: an=%b, required at most one low bit", an);
        end
    end

    function automatic void add(logic rst, logic [3:0] e_an, logic [6:0] e_seg, logic e_dp);
        vec_t v;
        v.rst = rst;
        v.en  = 1'b1;
        v.sd  = W_A;
        v.dd  = 4'b1000;
        v.an  = e_an;
        v.seg = e_seg;
        v.dp  = e_dp;
        tbl.push_back(v);
    endfunction

    function automatic void add_slot(logic [3:0] e_an, logic [6:0] e_seg, logic e_dp);
        for (int i = 0; i < 2; i++) add(1'b0, 4'hF, 7'h7F, 1'b1);
        for (int i = 0; i < 6; i++) add(1'b0, e_an, e_seg, e_dp);
    endfunction

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check(input string name, input logic [3:0] e_an,
                         input logic [6:0] e_seg, input logic e_dp);
        n_vec++;
        if (an !== e_an || seg !== e_seg || dp !== e_dp) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                     name, an, seg, dp, e_an, e_seg, e_dp);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        reset    = 1'b1;
        enable   = 1'b1;
        seg_data = W_A;
        dp_data  = 4'b1000;

        // Reset held 5 cycles, then frames 0..2 after release.
        for (int i = 0; i < 5; i++) add(1'b1, 4'hF, 7'h7F, 1'b1);
        // Frame 0: word A, dp 1000 (input changes mid-frame must not show)
        add_slot(4'b0111, 7'h79, 1'b0);
        add_slot(4'b1011, 7'h61, 1'b1);
        add_slot(4'b1101, 7'h11, 1'b1);
        add_slot(4'b1110, 7'h61, 1'b1);
        // Frame 1: word B, dp 0101
        add_slot(4'b0111, 7'h24, 1'b1);
        add_slot(4'b1011, 7'h0B, 1'b0);
        add_slot(4'b1101, 7'h11, 1'b1);
        add_slot(4'b1110, 7'h12, 1'b0);
        // Frame 2: all-blank codes, dp 0000
        add_slot(4'b0111, 7'h7F, 1'b1);
        add_slot(4'b1011, 7'h7F, 1'b1);
        add_slot(4'b1101, 7'h7F, 1'b1);
        add_slot(4'b1110, 7'h7F, 1'b1);

        // Input schedule by edge number: A until edge 11, B from 12, C from 40.
        for (int i = 5; i < tbl.size(); i++) begin
            int e;
            e = i - 4;
            if (e < 12) begin
                tbl[i].sd = W_A; tbl[i].dd = 4'b1000;
            end else if (e < 40) begin
                tbl[i].sd = W_B; tbl[i].dd = 4'b0101;
            end else begin
                tbl[i].sd = W_C; tbl[i].dd = 4'b0000;
            end
        end

        for (int i = 0; i < tbl.size(); i++) begin
            string nm;
            reset    = tbl[i].rst;
            enable   = tbl[i].en;
            seg_data = tbl[i].sd;
            dp_data  = tbl[i].dd;
            step();
            nm = $sformatf("vec[%0d]", i);
            check(nm, tbl[i].an, tbl[i].seg, tbl[i].dp);
        end

        // Enable dropped after edge 20 for three edges, new word loaded meanwhile.
        reset    = 1'b1;
        seg_data = W_A;
        dp_data  = 4'b0000;
        step();
        check("rst2", 4'hF, 7'h7F, 1'b1);
        reset = 1'b0;
        run(19);
        check("en_e19", 4'b1101, 7'h11, 1'b1);
        step();
        check("en_e20", 4'b1101, 7'h11, 1'b1);
        enable   = 1'b0;
        seg_data = W_D;
        step();
        check("en_off_e21", 4'hF, 7'h7F, 1'b1);
        step();
        check("en_off_e22", 4'hF, 7'h7F, 1'b1);
        step();
        check("en_off_e23", 4'hF, 7'h7F, 1'b1);
        enable = 1'b1;
        step();
        check("en_on_e24", 4'hF, 7'h7F, 1'b1);
        step();
        check("en_on_e25", 4'hF, 7'h7F, 1'b1);
        step();
        check("en_on_e26", 4'b0111, 7'h10, 1'b1);
        run(5);
        check("en_on_e31", 4'b0111, 7'h10, 1'b1);
        step();
        check("en_on_e32", 4'hF, 7'h7F, 1'b1);
        run(2);
        check("en_on_e34", 4'b1011, 7'h00, 1'b1);

        // Reset in the middle of a lit slot: dark next edge, no partial digit after.
        run(2);
        check("pre_rst_e36", 4'b1011, 7'h00, 1'b1);
        reset = 1'b1;
        step();
        check("mid_rst_a", 4'hF, 7'h7F, 1'b1);
        step();
        check("mid_rst_b", 4'hF, 7'h7F, 1'b1);
        reset = 1'b0;
        step();
        check("post_rst_e1", 4'hF, 7'h7F, 1'b1);
        step();
        check("post_rst_e2", 4'hF, 7'h7F, 1'b1);
        step();
        check("post_rst_e3", 4'b0111, 7'h10, 1'b1);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the 4-digit common-anode seven-segment display. It consumes the 20-bit character word (four 5-bit char codes) and the 4-bit decimal-point mask produced by the mode display blocks (clock, stopwatch, credits). It decodes the active digit's code, drives the active-low anode and segment pins, and inserts anti-ghost blanking between digits. The input word is snapshotted once per frame, so a display update never tears mid-scan.

## Interface
- SCAN_DIV, 100_000: clk cycles per digit slot (1 kHz slot rate at 100 MHz); ≥ 4.
- BLANK_CYCLES, 1_000: cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYCLES < SCAN_DIV.
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- enable  in  1  high = scan; low = display dark, scan state held at frame start.
- seg_data  in  20  char codes, [19:15] = leftmost digit 3 … [4:0] = digit 0.
- dp_data  in  4  decimal-point mask, bit 3 = leftmost; 1 = lit.
- an  out  4  anode enables, active-low, an[3] = leftmost.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

## Operation
- Slot counter `cnt` runs 0…SCAN_DIV-1 and wraps. Digit index `idx` starts at 3. On wrap, `idx` steps 3→2→1→0→3.
- Snapshot: `snap_seg`/`snap_dp` load seg_data/dp_data on every non-reset, enabled edge where the current state is cnt==0 and idx==3 (frame start).
- Output stage, registered from the current state:
  - if cnt < BLANK_CYCLES: an=1111, seg=7'h7F, dp=1.
  - else: an = one-hot-low at idx; seg = ~decode(snap_seg[idx]); dp = ~snap_dp[idx].
- Decode, active-high gfedcba hex: 0:3F 1:06 2:5B 3:4F 4:66 5:6D(also S) 6:7D 7:07 8:7F 9:6F 10 A:77 11 C:39 12 E:79 13 F:71 14 h:74 15 L:38 16 n:54 17 o:5C 18 b:7C 19 d:5E 20 P:73 21 J:1E 22 y:6E 23 U:3E 24 r:50 25 t:78 26 -:40 27 _:08 28–31 blank:00.
- enable low:
  - next edge: cnt=0, idx=3, outputs all off.
  - snapshot is not loaded while enable is low.
  - on re-enable, behaviour is identical to post-reset.
- Only frame-start input changes are displayed. Mid-frame changes take effect at the next frame start.

## Timing
- Reset (synchronous): cnt=0, idx=3, snap_seg=all codes 31, snap_dp=0, an=1111, seg=7F, dp=1.
- Outputs lag the counter state by exactly 1 cycle.
- After reset deasserts, edge 1 loads the snapshot. Outputs stay dark through edge BLANK_CYCLES. Digit 3 is lit after edges BLANK_CYCLES+1 … SCAN_DIV.
- Frame = 4·SCAN_DIV cycles. Each digit is lit SCAN_DIV−BLANK_CYCLES cycles per frame.
- Reset or enable-low mid-slot: dark on the next edge, no partial digit afterwards.
- Exactly one anode is low at any time, or none. Never two.

## Structure
- Shared package `seg7_pkg`: char-code localparams (C_0…C_9, C_A, C_C, C_E, C_F, C_h, C_L, C_n, C_o, C_b, C_d, C_P, C_J, C_y, C_U, C_r, C_t, C_DASH, C_UNDER, C_BLANK=31) and the 5-bit code width. The mode blocks use the same codes.
- One sub-module, `seg7_char_decode`: combinational 5-bit code → 7-bit active-high pattern. Outputs are registered in the parent.

## Test plan
(Bench uses SCAN_DIV=8, BLANK_CYCLES=2.)
- Reset held 5 cycles, then released → an=1111, seg=7F, dp=1 during reset and after edges 1–2. First lit digit appears after edge 3.
- seg_data={1,21,22,21}, dp_data=1000 →
  - after edges 3–8: an=0111, seg=79, dp=0.
  - after edges 11–16: an=1011, seg=61, dp=1.
  - digit 1: seg=11. Digit 0: seg=61.
  - pattern repeats every 32 cycles.
- At edge 12, change seg_data to {2,14,22,5} → digits 2, 1, 0 of frame 1 unchanged. From edge 35: an=0111, seg=24.
- seg_data={28,29,30,31} → seg=7F in every lit slot while an still cycles 0111/1011/1101/1110.
- enable low at edge 20 for 3 cycles → all off from edge 21. On re-enable, digit 3 lit exactly 3 edges later with the new snapshot.
- Assertion across all tests: popcount(~an) ≤ 1 every cycle.
